// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller:
//             controller state encoding, bubble counter width and the EX
//             operand-mux select codes.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Bubble/occupancy down-counter width; covers LD_STALL <= 7, MC_CYCLES <= 15
    localparam int HZ_CNT_W = 4;
    typedef logic [HZ_CNT_W-1:0] hz_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_MC_BUSY = 2'd2
    } hz_state_t;

    // EX operand-mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;   // register file
    localparam logic [1:0] FWD_MEM = 2'b01;   // result sitting in MEM
    localparam logic [1:0] FWD_WB  = 2'b10;   // result sitting in WB

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_sel
//  Purpose  : Per-source dependency check of one ID operand against the EX and
//             MEM destinations. Produces the next-cycle forwarding select and
//             flags a dependency on a load still in EX.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int RA_W     = 2,
    parameter int ZERO_REG = 0
) (
    input  logic            i_id_valid,
    input  logic [RA_W-1:0] i_addr,
    input  logic            i_use,
    input  logic            i_ex_valid,
    input  logic            i_ex_wr_en,
    input  logic            i_ex_mem_read,
    input  logic [RA_W-1:0] i_ex_dest,
    input  logic            i_mem_valid,
    input  logic            i_mem_wr_en,
    input  logic [RA_W-1:0] i_mem_dest,
    output logic            o_ld_hit,
    output logic [1:0]      o_sel
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic w_zero_blk;
    logic w_ex_hit;
    logic w_mem_hit;

    // A hardwired-zero source never depends on anything
    assign w_zero_blk = ZERO_EN && (i_addr == '0);

    // Producer in EX / MEM writes the register this operand reads
    assign w_ex_hit  = i_ex_valid & i_ex_wr_en & i_use & i_id_valid &
                       (i_ex_dest == i_addr) & ~w_zero_blk;
    assign w_mem_hit = i_mem_valid & i_mem_wr_en & i_use & i_id_valid &
                       (i_mem_dest == i_addr) & ~w_zero_blk;

    // A load in EX cannot forward yet; the controller must stall instead
    assign o_ld_hit = w_ex_hit & i_ex_mem_read;

    // Youngest producer (EX) wins over the older one (MEM)
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit && !i_ex_mem_read) begin
            o_sel = FWD_MEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : Hazard controller for the 5-stage core. Generates load-use
//             interlock bubbles, multi-cycle EX stalls, redirect flushes,
//             registered EX operand-mux selects and a saturating stall-cycle
//             counter.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int RA_W      = 2,
    parameter int LD_STALL  = 1,
    parameter int MC_CYCLES = 4,
    parameter int ZERO_REG  = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_id_valid,
    input  logic [RA_W-1:0]  i_id_ra,
    input  logic [RA_W-1:0]  i_id_rb,
    input  logic             i_id_use_ra,
    input  logic             i_id_use_rb,
    input  logic             i_ex_valid,
    input  logic             i_ex_wr_en,
    input  logic             i_ex_mem_read,
    input  logic [RA_W-1:0]  i_ex_dest,
    input  logic             i_ex_mc_start,
    input  logic             i_mem_valid,
    input  logic             i_mem_wr_en,
    input  logic [RA_W-1:0]  i_mem_dest,
    input  logic             i_redirect,
    input  logic             i_stall_cnt_clr,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_stall_ex,
    output logic             o_bubble_mem,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Remaining-cycle counter preloads: the entry cycle is spent in IDLE,
    // the final cycle is the one where the counter reads zero.
    localparam hz_cnt_t LD_INIT = hz_cnt_t'((LD_STALL  > 1) ? (LD_STALL  - 2) : 0);
    localparam hz_cnt_t MC_INIT = hz_cnt_t'((MC_CYCLES > 2) ? (MC_CYCLES - 3) : 0);

    hz_state_t        r_state;
    hz_cnt_t          r_cnt;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;

    hz_state_t  w_state_nxt;
    hz_cnt_t    w_cnt_nxt;
    logic       w_stall_if;
    logic       w_stall_id;
    logic       w_flush_id;
    logic       w_flush_ex;
    logic       w_stall_ex;
    logic       w_bubble_mem;
    logic       w_ld_hit_a;
    logic       w_ld_hit_b;
    logic       w_ld_use;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    hazard_fwd_sel #(
        .RA_W     (RA_W),
        .ZERO_REG (ZERO_REG)
    ) u_fwd_a (
        .i_id_valid    (i_id_valid),
        .i_addr        (i_id_ra),
        .i_use         (i_id_use_ra),
        .i_ex_valid    (i_ex_valid),
        .i_ex_wr_en    (i_ex_wr_en),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_dest     (i_ex_dest),
        .i_mem_valid   (i_mem_valid),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_dest    (i_mem_dest),
        .o_ld_hit      (w_ld_hit_a),
        .o_sel         (w_sel_a)
    );

    hazard_fwd_sel #(
        .RA_W     (RA_W),
        .ZERO_REG (ZERO_REG)
    ) u_fwd_b (
        .i_id_valid    (i_id_valid),
        .i_addr        (i_id_rb),
        .i_use         (i_id_use_rb),
        .i_ex_valid    (i_ex_valid),
        .i_ex_wr_en    (i_ex_wr_en),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_dest     (i_ex_dest),
        .i_mem_valid   (i_mem_valid),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_dest    (i_mem_dest),
        .o_ld_hit      (w_ld_hit_b),
        .o_sel         (w_sel_b)
    );

    assign w_ld_use = w_ld_hit_a | w_ld_hit_b;

    // Next state and same-cycle pipeline controls; redirect > MC > load-use
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall_if   = 1'b0;
        w_stall_id   = 1'b0;
        w_flush_id   = 1'b0;
        w_flush_ex   = 1'b0;
        w_stall_ex   = 1'b0;
        w_bubble_mem = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_redirect) begin
                    w_flush_id = 1'b1;
                    w_flush_ex = 1'b1;
                end else if (i_ex_valid && i_ex_mc_start) begin
                    w_stall_if   = 1'b1;
                    w_stall_id   = 1'b1;
                    w_stall_ex   = 1'b1;
                    w_bubble_mem = 1'b1;
                    if (MC_CYCLES > 2) begin
                        w_state_nxt = ST_MC_BUSY;
                        w_cnt_nxt   = MC_INIT;
                    end
                end else if (w_ld_use) begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_flush_ex = 1'b1;
                    if (LD_STALL > 1) begin
                        w_state_nxt = ST_LD_WAIT;
                        w_cnt_nxt   = LD_INIT;
                    end
                end
            end
            ST_LD_WAIT: begin
                if (i_redirect) begin
                    // The stalled consumer is on the wrong path: drop it
                    w_flush_id  = 1'b1;
                    w_flush_ex  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_flush_ex = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - hz_cnt_t'(1);
                    end
                end
            end
            ST_MC_BUSY: begin
                // EX is frozen, so a new mc_start or redirect cannot appear
                w_stall_if   = 1'b1;
                w_stall_id   = 1'b1;
                w_stall_ex   = 1'b1;
                w_bubble_mem = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - hz_cnt_t'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Controller state and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operand selects travel with the instruction into ID/EX; a bubble gets RF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (!w_stall_ex) begin
            if (w_flush_ex || i_redirect) begin
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end else begin
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end
        end
    end

    // Saturating count of front-end stall cycles; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_if && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Controls are forced low for the whole time reset is asserted
    assign o_stall_if   = w_stall_if   & rst_n;
    assign o_stall_id   = w_stall_id   & rst_n;
    assign o_flush_id   = w_flush_id   & rst_n;
    assign o_flush_ex   = w_flush_ex   & rst_n;
    assign o_stall_ex   = w_stall_ex   & rst_n;
    assign o_bubble_mem = w_bubble_mem & rst_n;
    assign o_fwd_a      = r_fwd_a;
    assign o_fwd_b      = r_fwd_b;
    assign o_stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_unit
//  Purpose  : Self-checking bench for hazard_ctrl_unit. Three parameter sets
//             share one directed stimulus stream; a behavioural model tracks
//             remaining stall cycles per instance and is compared every cycle,
//             with hand-computed literal checks at key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int NI = 3;
    localparam int LDP [NI] = '{1, 3, 7};
    localparam int MCP [NI] = '{4, 4, 2};
    localparam int ZRP [NI] = '{0, 1, 0};
    localparam int CWP [NI] = '{16, 2, 16};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_ra, id_use_rb;
    logic [1:0] id_ra, id_rb, ex_dest, mem_dest;
    logic       ex_valid, ex_wr_en, ex_mem_read, ex_mc_start;
    logic       mem_valid, mem_wr_en, redirect, stall_cnt_clr;

    // {stall_if, stall_id, flush_id, flush_ex, stall_ex, bubble_mem}
    wire [5:0]  d_comb [NI];
    wire [1:0]  d_fa   [NI];
    wire [1:0]  d_fb   [NI];
    wire [15:0] d_cnt  [NI];

    int  n_chk = 0;
    int  n_fail = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic sif, sid, fid, fex, sex, bm;
        logic [1:0] fa, fb;
        logic [CWP[g]-1:0] sc;
        hazard_ctrl_unit #(
            .RA_W(2), .LD_STALL(LDP[g]), .MC_CYCLES(MCP[g]),
            .ZERO_REG(ZRP[g]), .CNT_W(CWP[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .i_id_valid(id_valid), .i_id_ra(id_ra), .i_id_rb(id_rb),
            .i_id_use_ra(id_use_ra), .i_id_use_rb(id_use_rb),
            .i_ex_valid(ex_valid), .i_ex_wr_en(ex_wr_en), .i_ex_mem_read(ex_mem_read),
            .i_ex_dest(ex_dest), .i_ex_mc_start(ex_mc_start),
            .i_mem_valid(mem_valid), .i_mem_wr_en(mem_wr_en), .i_mem_dest(mem_dest),
            .i_redirect(redirect), .i_stall_cnt_clr(stall_cnt_clr),
            .o_stall_if(sif), .o_stall_id(sid), .o_flush_id(fid), .o_flush_ex(fex),
            .o_stall_ex(sex), .o_bubble_mem(bm), .o_fwd_a(fa), .o_fwd_b(fb),
            .o_stall_cnt(sc)
        );
        assign d_comb[g] = {sif, sid, fid, fex, sex, bm};
        assign d_fa[g]   = fa;
        assign d_fb[g]   = fb;
        assign d_cnt[g]  = 16'(sc);
    end

    // ---------------- behavioural model ----------------
    int         ld_rem [NI];   // load bubbles still owed after this cycle
    int         mc_rem [NI];   // multi-cycle stall cycles still owed
    logic [1:0] m_fa   [NI];
    logic [1:0] m_fb   [NI];
    int         m_cnt  [NI];

    function automatic bit is_match(int k, logic v, logic w, logic [1:0] dst,
                                    logic use_s, logic [1:0] addr);
        return v && w && use_s && id_valid && (dst == addr) &&
               !((ZRP[k] != 0) && (addr == 2'd0));
    endfunction

    function automatic bit ld_hazard(int k);
        return ex_mem_read &&
               (is_match(k, ex_valid, ex_wr_en, ex_dest, id_use_ra, id_ra) ||
                is_match(k, ex_valid, ex_wr_en, ex_dest, id_use_rb, id_rb));
    endfunction

    function automatic logic [1:0] exp_sel(int k, logic [1:0] addr, logic use_s);
        if (is_match(k, ex_valid, ex_wr_en, ex_dest, use_s, addr) && !ex_mem_read)
            return 2'b01;
        if (is_match(k, mem_valid, mem_wr_en, mem_dest, use_s, addr))
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [5:0] exp_comb(int k);
        if (!rst_n)                     return 6'b000000;
        if (mc_rem[k] > 0)              return 6'b110011;
        if (redirect)                   return 6'b001100;
        if (ld_rem[k] > 0)              return 6'b110100;
        if (ex_valid && ex_mc_start)    return 6'b110011;
        if (ld_hazard(k))               return 6'b110100;
        return 6'b000000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                ld_rem[k] <= 0; mc_rem[k] <= 0;
                m_fa[k] <= 2'b00; m_fb[k] <= 2'b00; m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin : b_step
                logic [5:0] e;
                e = exp_comb(k);
                if (mc_rem[k] > 0)                 mc_rem[k] <= mc_rem[k] - 1;
                else if (redirect)                 ld_rem[k] <= 0;
                else if (ld_rem[k] > 0)            ld_rem[k] <= ld_rem[k] - 1;
                else if (ex_valid && ex_mc_start)  mc_rem[k] <= MCP[k] - 2;
                else if (ld_hazard(k))             ld_rem[k] <= LDP[k] - 1;
                if (!e[1]) begin
                    if (e[2] || redirect) begin
                        m_fa[k] <= 2'b00; m_fb[k] <= 2'b00;
                    end else begin
                        m_fa[k] <= exp_sel(k, id_ra, id_use_ra);
                        m_fb[k] <= exp_sel(k, id_rb, id_use_rb);
                    end
                end
                if (stall_cnt_clr)                                  m_cnt[k] <= 0;
                else if (e[5] && m_cnt[k] < ((1 << CWP[k]) - 1))    m_cnt[k] <= m_cnt[k] + 1;
            end
        end
    end

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [u%0d] @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < NI; k++) begin
                check("ctrl", k, 32'(d_comb[k]), 32'(exp_comb(k)));
                check("fwd_a", k, 32'(d_fa[k]), 32'(m_fa[k]));
                check("fwd_b", k, 32'(d_fb[k]), 32'(m_fb[k]));
                check("stall_cnt", k, 32'(d_cnt[k]), 32'(m_cnt[k]));
                if (mc_rem[k] > 0)
                    check("redirect_in_mc_busy", k, 32'(redirect), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid = 0; id_ra = 0; id_rb = 0; id_use_ra = 0; id_use_rb = 0;
        ex_valid = 0; ex_wr_en = 0; ex_mem_read = 0; ex_dest = 0; ex_mc_start = 0;
        mem_valid = 0; mem_wr_en = 0; mem_dest = 0; redirect = 0; stall_cnt_clr = 0;
    endtask

    task automatic load_hz(input logic [1:0] r);
        idle_in();
        ex_valid = 1; ex_wr_en = 1; ex_mem_read = 1; ex_dest = r;
        id_valid = 1; id_ra = r; id_use_ra = 1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); idle_in();
        end
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        tick();
        cmp_en = 1;
        tick(); #3;
        check("reset ctrl", 0, 32'(d_comb[0]), 32'd0);
        check("reset fwd_a", 0, 32'(d_fa[0]), 32'd0);
        check("reset stall_cnt", 1, 32'(d_cnt[1]), 32'd0);
        rst_n = 1;

        // Load-use: LD_STALL=1 (u0) one bubble then WB forward; LD_STALL=3 (u1) three
        tick(); load_hz(2'd2); #3;
        check("ld u0 stall_if/id/flush_ex", 0, 32'(d_comb[0]), 32'b110100);
        check("ld u1 stall_if", 1, 32'(d_comb[1][5]), 32'd1);
        tick(); idle_in(); mem_valid = 1; mem_wr_en = 1; mem_dest = 2;
        id_valid = 1; id_ra = 2; id_use_ra = 1; #3;
        check("ld u0 released", 0, 32'(d_comb[0][5]), 32'd0);
        check("ld u1 bubble 2", 1, 32'(d_comb[1][5]), 32'd1);
        tick(); idle_in(); #3;
        check("ld u0 fwd_a WB", 0, 32'(d_fa[0]), 32'b10);
        check("ld u1 bubble 3", 1, 32'(d_comb[1][5]), 32'd1);
        tick(); #3;
        check("ld u1 released", 1, 32'(d_comb[1][5]), 32'd0);
        idle_cycles(7);

        // Redirect while u1/u2 wait on a load
        tick(); load_hz(2'd2);
        tick(); idle_in(); redirect = 1; #3;
        check("redir u1 flush no stall", 1, 32'(d_comb[1]), 32'b001100);
        tick(); idle_in(); #3;
        check("redir u1 back idle", 1, 32'(d_comb[1][5]), 32'd0);
        check("redir u2 aborted", 2, 32'(d_comb[2][5]), 32'd0);
        idle_cycles(2);

        // Multi-cycle op: prime fwd_a=01, then MC_CYCLES=4 holds 3 cycles
        tick(); idle_in(); ex_valid = 1; ex_wr_en = 1; ex_dest = 1;
        id_valid = 1; id_ra = 1; id_use_ra = 1;
        tick(); idle_in(); ex_valid = 1; ex_mc_start = 1;
        mem_valid = 1; mem_wr_en = 1; mem_dest = 3; id_valid = 1; id_ra = 3; id_use_ra = 1; #3;
        check("mc u0 stall set", 0, 32'(d_comb[0]), 32'b110011);
        check("mc u0 fwd_a c1", 0, 32'(d_fa[0]), 32'b01);
        for (int c = 2; c <= 3; c++) begin
            tick(); ex_mc_start = 0; #3;
            check("mc u0 still stalled", 0, 32'(d_comb[0][5]), 32'd1);
        end
        tick(); idle_in(); #3;
        check("mc u0 released", 0, 32'(d_comb[0][1]), 32'd0);
        check("mc u0 fwd_a held", 0, 32'(d_fa[0]), 32'b01);
        idle_cycles(2);

        // Forward select priority on source b
        tick(); idle_in(); ex_valid = 1; ex_wr_en = 1; ex_dest = 1;
        mem_valid = 1; mem_wr_en = 1; mem_dest = 1; id_valid = 1; id_rb = 1; id_use_rb = 1;
        tick(); ex_wr_en = 0; #3;
        check("fwd_b EX wins", 0, 32'(d_fb[0]), 32'b01);
        tick(); id_use_rb = 0; #3;
        check("fwd_b MEM", 0, 32'(d_fb[0]), 32'b10);
        tick(); idle_in(); #3;
        check("fwd_b unused", 0, 32'(d_fb[0]), 32'b00);

        // Register zero: only the ZERO_REG=1 instance ignores it
        tick(); load_hz(2'd0); #3;
        check("zr u1 no stall", 1, 32'(d_comb[1]), 32'd0);
        check("zr u0 stalls", 0, 32'(d_comb[0][5]), 32'd1);
        tick(); idle_in(); #3;
        check("zr u1 fwd_a", 1, 32'(d_fa[1]), 32'b00);
        idle_cycles(8);

        // Stall counter on CNT_W=2 instance
        tick(); idle_in(); stall_cnt_clr = 1;
        tick(); load_hz(2'd2); #3;
        check("cnt cleared", 1, 32'(d_cnt[1]), 32'd0);
        idle_cycles(2);
        tick(); load_hz(2'd2); #3;
        check("cnt after 3", 1, 32'(d_cnt[1]), 32'd3);
        tick(); idle_in(); stall_cnt_clr = 1; #3;
        check("cnt saturated", 1, 32'(d_cnt[1]), 32'd3);
        check("cnt clr cycle stalls", 1, 32'(d_comb[1][5]), 32'd1);
        tick(); idle_in(); #3;
        check("cnt clr wins", 1, 32'(d_cnt[1]), 32'd0);
        idle_cycles(6);

        // Asynchronous reset in the middle of LD_WAIT
        tick(); load_hz(2'd2);
        tick(); idle_in(); #2;
        check("pre-reset u1 in wait", 1, 32'(d_comb[1][5]), 32'd1);
        rst_n = 0; #1;
        check("async rst u1 ctrl", 1, 32'(d_comb[1]), 32'd0);
        check("async rst u1 cnt", 1, 32'(d_cnt[1]), 32'd0);
        check("async rst u2 ctrl", 2, 32'(d_comb[2]), 32'd0);
        tick(); tick();
        rst_n = 1;
        idle_cycles(3);
        @(posedge clk);
        cmp_en = 0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
